// File: rtl/regfile_param.sv
// Two-read / one-write register file with same-cycle write bypass and a
// post-reset clearing sweep. Define RF_X0_ZERO_EN to hardwire register 0 to zero.
module regfile_param #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [XLEN-1:0]   rd_data_1,
    output logic [XLEN-1:0]   rd_data_2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    output logic              ready,
    output logic              wr_err
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADDR_W:0]   NREGS_W  = (ADDR_W+1)'(NREGS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;
    logic              ready_reg, ready_next;
    logic              wr_err_reg, wr_err_next;
    logic [XLEN-1:0]   mem [NREGS];

    logic wr_in_range;
    logic wr_x0;
    logic wr_accept;
    logic wr_reject;

    assign wr_in_range = ({1'b0, wr_addr} < NREGS_W);
`ifdef RF_X0_ZERO_EN
    assign wr_x0 = (wr_addr == '0);
`else
    assign wr_x0 = 1'b0;
`endif
    // Writes to a hardwired x0 are dropped quietly, so they are neither accepted nor rejected.
    assign wr_accept = (state_reg == RUN) && wr_en && wr_in_range && !wr_x0;
    assign wr_reject = wr_en && ((state_reg == INIT) || !wr_in_range);

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        ready_next  = ready_reg;
        wr_err_next = wr_reject;
        if (state_reg == INIT) begin
            if (idx_reg == LAST_IDX) begin
                state_next = RUN;
                ready_next = 1'b1;
            end else begin
                idx_next = idx_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= INIT;
            idx_reg    <= '0;
            ready_reg  <= 1'b0;
            wr_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            ready_reg  <= ready_next;
            wr_err_reg <= wr_err_next;
        end
    end

    // Contents are left alone on a reset edge; the sweep that follows clears them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                if (state_reg == INIT) begin
                    if (idx_reg == ADDR_W'(i)) mem[i] <= '0;
                end else if (wr_accept && (wr_addr == ADDR_W'(i))) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

    logic [1:0][ADDR_W-1:0] rd_addr_arr;
    logic [1:0][XLEN-1:0]   rd_data_arr;

    assign rd_addr_arr[0] = rd_addr_1;
    assign rd_addr_arr[1] = rd_addr_2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
            logic [XLEN-1:0] rd_val;

            always_comb begin
                rd_val = '0;
                if ((state_reg == RUN) && ({1'b0, rd_addr_arr[gi]} < NREGS_W)) begin
                    for (int i = 0; i < NREGS; i++) begin
                        if (rd_addr_arr[gi] == ADDR_W'(i)) rd_val = mem[i];
                    end
                    if (wr_accept && (wr_addr == rd_addr_arr[gi])) rd_val = wr_data;
                end
`ifdef RF_X0_ZERO_EN
                if (rd_addr_arr[gi] == '0) rd_val = '0;
`endif
            end

            assign rd_data_arr[gi] = rd_val;
        end
    endgenerate

    assign rd_data_1 = rd_data_arr[0];
    assign rd_data_2 = rd_data_arr[1];
    assign ready     = ready_reg;
    assign wr_err    = wr_err_reg;

endmodule
